// File: rtl/cpu_run_monitor.sv
// Run-control monitor beside the CPU: counts cycles and retires and ends a run
// on a halt PC, a stalled PC or an exhausted cycle budget.
module cpu_run_monitor #(
   parameter int PC_WIDTH    = 32,
   parameter int CNT_WIDTH   = 32,
   parameter int STALL_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 retire,
   input  logic [PC_WIDTH-1:0]  halt_pc,
   input  logic                 halt_pc_en,
   input  logic [CNT_WIDTH-1:0] max_cycles,
   output logic                 running,
   output logic                 done,
   output logic [1:0]           status,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   // stall_q counts equal compares; STALL_LIMIT-1 of them means STALL_LIMIT samples
   localparam logic [7:0] STALL_FIRE = 8'(STALL_LIMIT - 2);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cyc_q, cyc_d, ins_q, ins_d;
   logic [CNT_WIDTH-1:0]  cyc_inc, ins_inc;
   logic [1:0]            status_q, status_d;
   logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d;
   logic [7:0]            stall_q, stall_d;
   logic                  pc_same, hit_halt, hit_stall, hit_budget;

   always_comb begin
      cyc_inc    = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
      ins_inc    = (retire && ins_q != CNT_MAX) ? ins_q + CNT_ONE : ins_q;
      pc_same    = (pc == prev_pc_q);
      hit_halt   = halt_pc_en && (pc == halt_pc);
      hit_stall  = pc_same && (stall_q == STALL_FIRE);
      hit_budget = (max_cycles != '0) && (cyc_inc == max_cycles);

      state_d   = state_q;
      cyc_d     = cyc_q;
      ins_d     = ins_q;
      status_d  = status_q;
      prev_pc_d = prev_pc_q;
      stall_d   = stall_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               cyc_d     = '0;
               ins_d     = '0;
               status_d  = 2'b00;
               prev_pc_d = pc;
               stall_d   = '0;
            end
         end
         RUN: begin
            cyc_d     = cyc_inc;
            ins_d     = ins_inc;
            prev_pc_d = pc;
            stall_d   = pc_same ? stall_q + 8'd1 : 8'd0;
            if (hit_halt || hit_stall || hit_budget) begin
               state_d = DONE;
               if (hit_halt)       status_d = 2'b01;
               else if (hit_stall) status_d = 2'b10;
               else                status_d = 2'b11;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cyc_q     <= '0;
         ins_q     <= '0;
         status_q  <= 2'b00;
         prev_pc_q <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         ins_q     <= ins_d;
         status_q  <= status_d;
         prev_pc_q <= prev_pc_d;
         stall_q   <= stall_d;
      end
   end

   assign running     = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign status      = status_q;
   assign cycle_count = cyc_q;
   assign instr_count = ins_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed scenarios plus random runs checked
// against a sample-history model of the run rules.
module tb_cpu_run_monitor;

   localparam int  PCW = 32;
   localparam int  CW  = 32;
   localparam int  SL  = 16;
   localparam longint CMAX = (longint'(1) << CW) - 1;

   logic           clk = 1'b0;
   logic           reset, start, retire, halt_pc_en;
   logic [PCW-1:0] pc, halt_pc;
   logic [CW-1:0]  max_cycles;
   logic [3:0]     sat_max;

   logic           running, done;
   logic [1:0]     status;
   logic [CW-1:0]  cycle_count, instr_count;
   logic           s_running, s_done;
   logic [1:0]     s_status;
   logic [3:0]     s_cycle, s_instr;

   int checks = 0;
   int errors = 0;

   typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;
   mstate_e        m_state;
   longint         m_cyc, m_ins;
   logic [1:0]     m_status;
   logic [PCW-1:0] hist[$];

   cpu_run_monitor #(.PC_WIDTH(PCW), .CNT_WIDTH(CW), .STALL_LIMIT(SL)) dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc), .retire(retire),
      .halt_pc(halt_pc), .halt_pc_en(halt_pc_en), .max_cycles(max_cycles),
      .running(running), .done(done), .status(status),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   cpu_run_monitor #(.PC_WIDTH(PCW), .CNT_WIDTH(4), .STALL_LIMIT(SL)) sdut (
      .clk(clk), .reset(reset), .start(start), .pc(pc), .retire(retire),
      .halt_pc(halt_pc), .halt_pc_en(halt_pc_en), .max_cycles(sat_max),
      .running(s_running), .done(s_done), .status(s_status),
      .cycle_count(s_cycle), .instr_count(s_instr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state  = M_IDLE;
      m_cyc    = 0;
      m_ins    = 0;
      m_status = 2'b00;
      hist.delete();
   endtask

   // Applies the run rules to the inputs that the coming rising edge samples.
   task automatic model_edge();
      bit     halt, stall, budget;
      longint nc;
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_state != M_RUN) begin
         if (start) begin
            m_state  = M_RUN;
            m_cyc    = 0;
            m_ins    = 0;
            m_status = 2'b00;
            hist.delete();
            hist.push_back(pc);
         end
      end else begin
         nc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
         if (retire && m_ins < CMAX) m_ins = m_ins + 1;
         hist.push_back(pc);
         if (hist.size() > SL) void'(hist.pop_front());
         stall = (hist.size() == SL);
         foreach (hist[i]) if (hist[i] !== pc) stall = 0;
         halt   = halt_pc_en && (pc == halt_pc);
         budget = (max_cycles != 0) && (nc == longint'(max_cycles));
         m_cyc  = nc;
         if (halt || stall || budget) begin
            m_state  = M_DONE;
            m_status = halt ? 2'b01 : (stall ? 2'b10 : 2'b11);
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; retire = 1'b0; pc = '0;
      halt_pc = '0; halt_pc_en = 1'b0; max_cycles = '0; sat_max = '0;
      #2 reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({running, done, status} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {running, done, status});
      end
      repeat (3) tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pc = (i % 2) ? 32'h4 : 32'h8;
         tick();
      end
      checks++;
      if ({running, done, status} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_flags: got %b expected 0000", {running, done, status});
      end
      checks++;
      if (cycle_count !== 0 || instr_count !== 0) begin
         errors++;
         $display("FAIL idle_counts: got %0d/%0d expected 0/0", cycle_count, instr_count);
      end
   endtask

   task automatic test_halt();
      int k;
      halt_pc_en = 1'b1; halt_pc = 32'h40; max_cycles = '0; retire = 1'b1;
      pc = 32'h100; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (running !== 1'b1 || cycle_count !== 0) begin
         errors++;
         $display("FAIL halt_enter: got run=%b cyc=%0d expected run=1 cyc=0", running, cycle_count);
      end
      for (k = 1; k <= 40; k++) begin
         pc = 32'(4 * (k - 1));
         tick();
         if (done) break;
      end
      checks++;
      if (done !== 1'b1 || running !== 1'b0 || status !== 2'b01) begin
         errors++;
         $display("FAIL halt_end: got done=%b run=%b st=%b expected 1 0 01", done, running, status);
      end
      checks++;
      if (cycle_count !== 17 || instr_count !== 17) begin
         errors++;
         $display("FAIL halt_counts: got %0d/%0d expected 17/17", cycle_count, instr_count);
      end
      repeat (3) begin
         pc = pc + 4;
         tick();
      end
      checks++;
      if (cycle_count !== 17 || status !== 2'b01 || done !== 1'b1) begin
         errors++;
         $display("FAIL halt_hold: got cyc=%0d st=%b expected 17 01", cycle_count, status);
      end
   endtask

   task automatic test_stall();
      int k;
      halt_pc_en = 1'b0; max_cycles = '0; retire = 1'b1;
      pc = '0; start = 1'b1;
      tick();
      start = 1'b0;
      for (k = 1; k <= 60; k++) begin
         pc = (k <= 5) ? 32'(4 * k) : 32'h14;
         tick();
         if (done) break;
      end
      checks++;
      if (done !== 1'b1 || status !== 2'b10) begin
         errors++;
         $display("FAIL stall_end: got done=%b st=%b expected 1 10", done, status);
      end
      checks++;
      if (cycle_count !== 20 || instr_count !== 20) begin
         errors++;
         $display("FAIL stall_counts: got %0d/%0d expected 20/20", cycle_count, instr_count);
      end
      repeat (5) begin
         pc = pc + 4;
         tick();
      end
      checks++;
      if (cycle_count !== 20 || instr_count !== 20 || status !== 2'b10) begin
         errors++;
         $display("FAIL stall_freeze: got %0d/%0d st=%b expected 20/20 10",
                  cycle_count, instr_count, status);
      end
   endtask

   task automatic test_budget();
      int  k;
      longint exp_ins;
      for (int pass = 0; pass < 2; pass++) begin
         max_cycles = 32'd500;
         halt_pc    = 32'h1000 + 32'(4 * 500);
         halt_pc_en = (pass == 1);
         pc = 32'h1000; start = 1'b1; retire = 1'b0;
         tick();
         start   = 1'b0;
         exp_ins = 0;
         for (k = 1; k <= 600; k++) begin
            pc     = 32'h1000 + 32'(4 * k);
            retire = 1'($urandom_range(0, 1));
            exp_ins += retire;
            tick();
            if (done) break;
         end
         retire = 1'b0;
         checks++;
         if (done !== 1'b1 || status !== (pass == 1 ? 2'b01 : 2'b11)) begin
            errors++;
            $display("FAIL budget_status%0d: got done=%b st=%b expected 1 %b",
                     pass, done, status, (pass == 1 ? 2'b01 : 2'b11));
         end
         checks++;
         if (cycle_count !== 500 || instr_count !== exp_ins) begin
            errors++;
            $display("FAIL budget_counts%0d: got %0d/%0d expected 500/%0d",
                     pass, cycle_count, instr_count, exp_ins);
         end
      end
      halt_pc_en = 1'b0;
      max_cycles = '0;
   endtask

   task automatic test_restart_and_reset();
      pc = 32'h2000; start = 1'b1; retire = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({running, done, status} !== 4'b1000 || cycle_count !== 0 || instr_count !== 0) begin
         errors++;
         $display("FAIL restart_clear: got r=%b d=%b st=%b %0d/%0d expected 1 0 00 0/0",
                  running, done, status, cycle_count, instr_count);
      end
      pc = pc + 4;
      tick();
      checks++;
      if (cycle_count !== 1 || instr_count !== 1) begin
         errors++;
         $display("FAIL restart_count: got %0d/%0d expected 1/1", cycle_count, instr_count);
      end
      pc = pc + 4; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (cycle_count !== 2 || running !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run: got cyc=%0d run=%b expected 2 1", cycle_count, running);
      end
      while (cycle_count < 37) begin
         pc = pc + 4;
         tick();
      end
      #2 reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({running, done, status} !== 4'b0000 || cycle_count !== 0 || instr_count !== 0) begin
         errors++;
         $display("FAIL midrun_reset: got r=%b d=%b st=%b %0d/%0d expected all 0",
                  running, done, status, cycle_count, instr_count);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_saturation();
      halt_pc_en = 1'b0; max_cycles = '0; sat_max = '0; retire = 1'b1;
      pc = 32'h300; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         pc = 32'h300 + 32'(4 * i);
         tick();
      end
      checks++;
      if (s_cycle !== 4'd15 || s_instr !== 4'd15) begin
         errors++;
         $display("FAIL sat_counts: got %0d/%0d expected 15/15", s_cycle, s_instr);
      end
      checks++;
      if (s_running !== 1'b1 || s_done !== 1'b0 || s_status !== 2'b00) begin
         errors++;
         $display("FAIL sat_flags: got r=%b d=%b st=%b expected 1 0 00", s_running, s_done, s_status);
      end
      checks++;
      if (cycle_count !== 30) begin
         errors++;
         $display("FAIL sat_wide: got %0d expected 30", cycle_count);
      end
   endtask

   task automatic test_random();
      int stuck = 0;
      for (int c = 0; c < 6000; c++) begin
         if (m_state == M_RUN) start = 1'($urandom_range(0, 49) == 0);
         else                  start = 1'($urandom_range(0, 7) == 0);
         if (start && m_state != M_RUN) begin
            halt_pc_en = 1'($urandom_range(0, 1));
            halt_pc    = 32'($urandom_range(0, 63) * 4);
            max_cycles = ($urandom_range(0, 2) == 0) ? '0 : 32'($urandom_range(5, 200));
         end
         if ($urandom_range(0, 99) == 0) max_cycles = 32'($urandom_range(1, 120));
         if ($urandom_range(0, 99) == 0) halt_pc = 32'($urandom_range(0, 63) * 4);
         if (stuck > 0) stuck--;
         else if ($urandom_range(0, 24) == 0) stuck = $urandom_range(5, 25);
         else pc = 32'($urandom_range(0, 63) * 4);
         retire = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (running !== (m_state == M_RUN) || done !== (m_state == M_DONE)) begin
            errors++;
            $display("FAIL rnd_flags@%0d: got r=%b d=%b expected r=%b d=%b", c,
                     running, done, m_state == M_RUN, m_state == M_DONE);
         end
         checks++;
         if (status !== m_status) begin
            errors++;
            $display("FAIL rnd_status@%0d: got %b expected %b", c, status, m_status);
         end
         checks++;
         if (cycle_count !== m_cyc || instr_count !== m_ins) begin
            errors++;
            $display("FAIL rnd_counts@%0d: got %0d/%0d expected %0d/%0d", c,
                     cycle_count, instr_count, m_cyc, m_ins);
         end
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_halt();
      test_stall();
      test_budget();
      test_restart_and_reset();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
